// File: rtl/gesture_pkg.sv
// Shared frame geometry and types for the gesture pipeline.
// Palm extraction and finger identification both use these definitions.
package gesture_pkg;

   localparam int IMAGE_WIDTH  = 160;
   localparam int IMAGE_HEIGHT = 120;

   typedef logic [7:0] coord_t;

   typedef struct packed {
      coord_t start_r;
      coord_t start_c;
      coord_t end_r;
      coord_t end_c;
      coord_t width;
      coord_t height;
   } bbox_t;

   typedef enum logic [1:0] {IDLE, SCAN, FINAL} state_t;

endpackage

// File: rtl/palm_bbox_extractor_row_run_detector.sv
// Per-row skin run tracking: qualifies a row once MIN_RUN consecutive skin pixels are seen.
// Outputs already include the current pixel, so the row can be committed on its last pixel.
module row_run_detector
   import gesture_pkg::*;
#(
   parameter int MIN_RUN = 4
)
(
   input  logic   clk,
   input  logic   rst,
   input  logic   valid,
   input  logic   skin,
   input  coord_t col,
   input  logic   row_start,
   output logic   qualified,
   output coord_t min_c,
   output coord_t max_c
);

   localparam coord_t RUN_MAX = coord_t'(MIN_RUN);
   localparam coord_t RUN_OFS = coord_t'(MIN_RUN - 1);

   coord_t run_q;
   coord_t run_d;
   logic   qual_q;
   coord_t min_q;
   coord_t max_q;

   // The row start discards the previous row's state before this pixel is applied.
   always_comb begin
      run_d     = row_start ? '0   : run_q;
      qualified = row_start ? 1'b0 : qual_q;
      min_c     = row_start ? '0   : min_q;
      max_c     = row_start ? '0   : max_q;
      if (skin) begin
         if (run_d < RUN_MAX) begin
            run_d = run_d + 8'd1;
         end
         if (run_d == RUN_MAX) begin
            if (!qualified) begin
               min_c = col - RUN_OFS;
            end
            qualified = 1'b1;
            max_c     = col;
         end
      end else begin
         run_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q  <= '0;
         qual_q <= 1'b0;
         min_q  <= '0;
         max_q  <= '0;
      end else if (valid) begin
         run_q  <= run_d;
         qual_q <= qualified;
         min_q  <= min_c;
         max_q  <= max_c;
      end
   end

endmodule

// File: rtl/palm_bbox_extractor.sv
// Palm bounding-box extractor: scans a raster skin mask and reports the box of qualified rows once per frame.
// Results are held between frames; a frame with too few qualified rows reports all zeros.
module palm_bbox_extractor
#(
   parameter int IMAGE_WIDTH   = gesture_pkg::IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT  = gesture_pkg::IMAGE_HEIGHT,
   parameter int MIN_RUN       = 4,
   parameter int MIN_PALM_ROWS = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_valid,
   input  logic       pix_sof,
   input  logic       pix_skin,
   output logic [7:0] palm_width,
   output logic [7:0] palm_height,
   output logic [7:0] start_of_palm_r,
   output logic [7:0] start_of_palm_c,
   output logic [7:0] end_of_palm_r,
   output logic [7:0] end_of_palm_c,
   output logic       palm_valid,
   output logic       frame_abort
);

   import gesture_pkg::*;

   localparam coord_t LAST_COL = coord_t'(IMAGE_WIDTH - 1);
   localparam coord_t LAST_ROW = coord_t'(IMAGE_HEIGHT - 1);
   localparam coord_t MIN_ROWS = coord_t'(MIN_PALM_ROWS);

   state_t state;
   coord_t col;
   coord_t row;
   coord_t cur_col;
   coord_t cur_row;
   logic   accept;
   logic   restart;
   logic   row_end;
   logic   last_pix;

   coord_t min_c, max_c, first_r, last_r, rows_cnt;
   coord_t base_min_c, base_max_c, base_first_r, base_last_r, base_rows;
   coord_t nxt_min_c, nxt_max_c, nxt_first_r, nxt_last_r, nxt_rows;

   logic   row_qualified;
   coord_t row_min_c;
   coord_t row_max_c;

   bbox_t  box;
   bbox_t  result;

   // A start-of-frame pixel restarts the scan at (0,0) except while results are being computed.
   always_comb begin
      restart  = pix_valid && pix_sof && (state != FINAL);
      accept   = restart || (pix_valid && (state == SCAN));
      cur_col  = restart ? '0 : col;
      cur_row  = restart ? '0 : row;
      row_end  = accept && (cur_col == LAST_COL);
      last_pix = row_end && (cur_row == LAST_ROW);
   end

   row_run_detector #(
      .MIN_RUN(MIN_RUN)
   ) u_run (
      .clk       (clk),
      .rst       (rst),
      .valid     (accept),
      .skin      (pix_skin),
      .col       (cur_col),
      .row_start (cur_col == '0),
      .qualified (row_qualified),
      .min_c     (row_min_c),
      .max_c     (row_max_c)
   );

   // Frame accumulators; a restart folds the current row into freshly cleared values.
   always_comb begin
      base_min_c   = restart ? 8'hFF : min_c;
      base_max_c   = restart ? 8'h00 : max_c;
      base_first_r = restart ? 8'h00 : first_r;
      base_last_r  = restart ? 8'h00 : last_r;
      base_rows    = restart ? 8'h00 : rows_cnt;
      nxt_min_c    = base_min_c;
      nxt_max_c    = base_max_c;
      nxt_first_r  = base_first_r;
      nxt_last_r   = base_last_r;
      nxt_rows     = base_rows;
      if (row_end && row_qualified) begin
         if (row_min_c < base_min_c) begin
            nxt_min_c = row_min_c;
         end
         if (row_max_c > base_max_c) begin
            nxt_max_c = row_max_c;
         end
         if (base_rows == '0) begin
            nxt_first_r = cur_row;
         end
         nxt_last_r = cur_row;
         if (base_rows != 8'hFF) begin
            nxt_rows = base_rows + 8'd1;
         end
      end
   end

   always_comb begin
      box = '0;
      if (rows_cnt >= MIN_ROWS) begin
         box.start_r = first_r;
         box.start_c = min_c;
         box.end_r   = last_r;
         box.end_c   = max_c;
         box.width   = max_c - min_c + 8'd1;
         box.height  = last_r - first_r + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         min_c       <= 8'hFF;
         max_c       <= '0;
         first_r     <= '0;
         last_r      <= '0;
         rows_cnt    <= '0;
         result      <= '0;
         palm_valid  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         palm_valid  <= 1'b0;
         frame_abort <= 1'b0;
         if (accept) begin
            min_c    <= nxt_min_c;
            max_c    <= nxt_max_c;
            first_r  <= nxt_first_r;
            last_r   <= nxt_last_r;
            rows_cnt <= nxt_rows;
            if (cur_col == LAST_COL) begin
               col <= '0;
               row <= cur_row + 8'd1;
            end else begin
               col <= cur_col + 8'd1;
               row <= cur_row;
            end
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= last_pix ? FINAL : SCAN;
               end
            end
            SCAN: begin
               if (restart) begin
                  frame_abort <= 1'b1;
               end
               if (last_pix) begin
                  state <= FINAL;
               end
            end
            FINAL: begin
               result     <= box;
               palm_valid <= 1'b1;
               col        <= '0;
               row        <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign start_of_palm_r = result.start_r;
   assign start_of_palm_c = result.start_c;
   assign end_of_palm_r   = result.end_r;
   assign end_of_palm_c   = result.end_c;
   assign palm_width      = result.width;
   assign palm_height     = result.height;

endmodule

// File: tb/tb_palm_bbox_extractor.sv
// Directed bench for palm_bbox_extractor with hand-computed bounding boxes.
// Frames are 160 x 64 so the corner palm sits on rows 60..63, cols 156..159.
module tb_palm_bbox_extractor;

   localparam int IMG_W     = 160;
   localparam int IMG_H     = 64;
   localparam int FRAME_PIX = IMG_W * IMG_H;

   localparam logic [47:0] RECT_BOX   = {8'd20, 8'd30,  8'd59, 8'd79,  8'd50, 8'd40};
   localparam logic [47:0] B_BOX      = {8'd10, 8'd0,   8'd19, 8'd9,   8'd10, 8'd10};
   localparam logic [47:0] CORNER_BOX = {8'd60, 8'd156, 8'd63, 8'd159, 8'd4,  8'd4};
   localparam logic [47:0] ZERO_BOX   = 48'd0;

   typedef enum int {M_RECT, M_NOISE, M_B, M_CORNER} mode_t;

   logic       clk;
   logic       rst;
   logic       pix_valid;
   logic       pix_sof;
   logic       pix_skin;
   logic [7:0] palm_width;
   logic [7:0] palm_height;
   logic [7:0] start_of_palm_r;
   logic [7:0] start_of_palm_c;
   logic [7:0] end_of_palm_r;
   logic [7:0] end_of_palm_c;
   logic       palm_valid;
   logic       frame_abort;

   int total = 0;
   int bad = 0;
   int abort_seen = 0;

   palm_bbox_extractor #(
      .IMAGE_WIDTH   (IMG_W),
      .IMAGE_HEIGHT  (IMG_H),
      .MIN_RUN       (4),
      .MIN_PALM_ROWS (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pix_valid       (pix_valid),
      .pix_sof         (pix_sof),
      .pix_skin        (pix_skin),
      .palm_width      (palm_width),
      .palm_height     (palm_height),
      .start_of_palm_r (start_of_palm_r),
      .start_of_palm_c (start_of_palm_c),
      .end_of_palm_r   (end_of_palm_r),
      .end_of_palm_c   (end_of_palm_c),
      .palm_valid      (palm_valid),
      .frame_abort     (frame_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (frame_abort === 1'b1) abort_seen <= abort_seen + 1;
   end

   function automatic logic [47:0] box_now();
      return {start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c, palm_width, palm_height};
   endfunction

   function automatic logic skin_at(mode_t m, int r, int c);
      case (m)
         M_RECT:  return (r >= 20 && r <= 59 && c >= 30 && c <= 79);
         M_NOISE: return (r % 5 == 0) && (c % 16 >= 2) && (c % 16 <= 4);
         M_B:     return (r >= 10 && r <= 19 && c <= 9);
         default: return (r >= IMG_H - 4 && c >= IMG_W - 4);
      endcase
   endfunction

   // Idle cycles carry random sof/skin to show they are ignored without pix_valid.
   task automatic send_pixel(input logic sof, input logic skin, input bit gappy);
      int gaps = 0;
      while (gappy && gaps < 3 && $urandom_range(0, 1) == 1) begin
         pix_valid = 1'b0;
         pix_sof   = 1'($urandom_range(0, 1));
         pix_skin  = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         gaps++;
      end
      pix_valid = 1'b1;
      pix_sof   = sof;
      pix_skin  = skin;
      @(posedge clk); #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_skin  = 1'b0;
   endtask

   task automatic send_frame(input mode_t m, input bit gappy, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         send_pixel(i == 0, skin_at(m, i / IMG_W, i % IMG_W), gappy);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_skin  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (box_now() !== ZERO_BOX) begin
         bad++;
         $display("[TB] FAIL reset_box: got %h want %h", box_now(), ZERO_BOX);
      end
      total++;
      if (palm_valid !== 1'b0 || frame_abort !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_pulses: palm_valid=%b frame_abort=%b want 0 0", palm_valid, frame_abort);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) send_pixel(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_rect();
      send_frame(M_RECT, 1'b0, 0, FRAME_PIX - 1);
      total++;
      if (palm_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rect_pv_early: palm_valid=%b want 0", palm_valid);
      end
      @(posedge clk); #1;
      total++;
      if (palm_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rect_pv_latency: palm_valid=%b want 1", palm_valid);
      end
      total++;
      if (box_now() !== RECT_BOX) begin
         bad++;
         $display("[TB] FAIL rect_box: got %h want %h", box_now(), RECT_BOX);
      end
      @(posedge clk); #1;
      total++;
      if (palm_valid !== 1'b0 || box_now() !== RECT_BOX) begin
         bad++;
         $display("[TB] FAIL rect_hold: palm_valid=%b box=%h want 0 %h", palm_valid, box_now(), RECT_BOX);
      end
      total++;
      if (abort_seen != 0) begin
         bad++;
         $display("[TB] FAIL rect_no_abort: aborts=%0d want 0", abort_seen);
      end
   endtask

   task automatic test_abort();
      send_frame(M_RECT, 1'b0, 0, 50 * IMG_W - 1);
      send_frame(M_B, 1'b0, 0, 0);
      total++;
      if (frame_abort !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_pulse: frame_abort=%b want 1", frame_abort);
      end
      total++;
      if (box_now() !== RECT_BOX) begin
         bad++;
         $display("[TB] FAIL abort_keep: got %h want %h", box_now(), RECT_BOX);
      end
      send_frame(M_B, 1'b0, 1, FRAME_PIX - 2);
      total++;
      if (box_now() !== RECT_BOX || palm_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_hold_b: box=%h pv=%b want %h 0", box_now(), palm_valid, RECT_BOX);
      end
      send_frame(M_B, 1'b0, FRAME_PIX - 1, FRAME_PIX - 1);
      @(posedge clk); #1;
      total++;
      if (palm_valid !== 1'b1 || box_now() !== B_BOX) begin
         bad++;
         $display("[TB] FAIL b_box: pv=%b box=%h want 1 %h", palm_valid, box_now(), B_BOX);
      end
      total++;
      if (abort_seen != 1) begin
         bad++;
         $display("[TB] FAIL abort_count: aborts=%0d want 1", abort_seen);
      end
   endtask

   task automatic test_reset_mid_scan();
      send_frame(M_RECT, 1'b0, 0, 25 * IMG_W + 40);
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (box_now() !== ZERO_BOX || palm_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midscan_reset: box=%h pv=%b want %h 0", box_now(), palm_valid, ZERO_BOX);
      end
      rst = 1'b0;
   endtask

   task automatic test_gaps();
      send_frame(M_RECT, 1'b1, 0, FRAME_PIX - 1);
      total++;
      if (palm_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL gaps_pv_early: palm_valid=%b want 0", palm_valid);
      end
      @(posedge clk); #1;
      total++;
      if (palm_valid !== 1'b1 || box_now() !== RECT_BOX) begin
         bad++;
         $display("[TB] FAIL gaps_box: pv=%b box=%h want 1 %h", palm_valid, box_now(), RECT_BOX);
      end
      total++;
      if (abort_seen != 1) begin
         bad++;
         $display("[TB] FAIL gaps_no_abort: aborts=%0d want 1", abort_seen);
      end
   endtask

   task automatic test_corner();
      send_frame(M_CORNER, 1'b0, 0, FRAME_PIX - 1);
      @(posedge clk); #1;
      total++;
      if (palm_valid !== 1'b1 || box_now() !== CORNER_BOX) begin
         bad++;
         $display("[TB] FAIL corner_box: pv=%b box=%h want 1 %h", palm_valid, box_now(), CORNER_BOX);
      end
   endtask

   task automatic test_noise();
      send_frame(M_NOISE, 1'b0, 0, FRAME_PIX - 1);
      @(posedge clk); #1;
      total++;
      if (palm_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL noise_pv: palm_valid=%b want 1", palm_valid);
      end
      total++;
      if (box_now() !== ZERO_BOX) begin
         bad++;
         $display("[TB] FAIL noise_box: got %h want %h", box_now(), ZERO_BOX);
      end
      @(posedge clk); #1;
      total++;
      if (palm_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL noise_pv_single: palm_valid=%b want 0", palm_valid);
      end
   endtask

   initial begin
      test_reset();
      test_rect();
      test_abort();
      test_reset_mid_scan();
      test_gaps();
      test_corner();
      test_noise();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
